// File: rtl/operand_fetch.sv
// operand_fetch: operand-fetch stage between decode and execute.
// Drives the register file read selects combinationally from the incoming
// instruction. It collects the read data one cycle later and merges
// writebacks: those in the accept cycle and those that arrive while the
// instruction is held. A pending scoreboard stalls consumers of registers
// whose producer has left this stage but has not yet written back.
//
// Handshake semantics (both ports): a transfer happens on a rising edge where
// valid && ready are both high. A producer holding valid keeps its payload
// stable until that transfer. in_ready depends combinationally on out_ready
// (a handshake frees stage B for a new instruction on the same edge).
// in_ready never depends on rf_rdata.
module operand_fetch #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  // decode side
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [4:0]      in_rd,
  input  logic            in_rd_wen,
  input  logic [31:0]     in_pc,
  // register file read port (synchronous read, data one cycle later)
  output logic [4:0]      rf_rsel1,
  output logic [4:0]      rf_rsel2,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  // writeback applied to the register file this cycle
  input  logic            wb_wen,
  input  logic [4:0]      wb_sel,
  input  logic [XLEN-1:0] wb_data,
  // execute side
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rs1_val,
  output logic [XLEN-1:0] out_rs2_val,
  output logic [4:0]      out_rd,
  output logic            out_rd_wen,
  output logic [31:0]     out_pc
);

  // ---------------------------------------------------------------------
  // Stage B state
  // ---------------------------------------------------------------------
  logic            b_valid_q,  b_valid_d;
  logic [4:0]      b_rs1_q,    b_rs1_d;
  logic [4:0]      b_rs2_q,    b_rs2_d;
  logic [4:0]      b_rd_q,     b_rd_d;
  logic            b_rd_wen_q, b_rd_wen_d;
  logic [31:0]     b_pc_q,     b_pc_d;
  logic [XLEN-1:0] op1_q,      op1_d;
  logic [XLEN-1:0] op2_q,      op2_d;
  // use_rf: the operand still has to come from the register file read data
  // (true only during the first cycle in B without a same-edge bypass)
  logic            use_rf1_q,  use_rf1_d;
  logic            use_rf2_q,  use_rf2_d;

  // Scoreboard: one bit per architectural register with a producer in flight
  logic [31:0]     pending_q,  pending_d;

  // ---------------------------------------------------------------------
  // Control signals
  // ---------------------------------------------------------------------
  logic            src1_pending;
  logic            src2_pending;
  logic            handshake;
  logic            accept;
  logic            wb_hit1_in;
  logic            wb_hit2_in;
  logic            wb_hit1_b;
  logic            wb_hit2_b;
  logic            wb_clears;
  logic            hs_sets;
  logic [XLEN-1:0] opnd1;
  logic [XLEN-1:0] opnd2;

  // Read selects follow the incoming instruction at all times
  assign rf_rsel1 = in_rs1;
  assign rf_rsel2 = in_rs2;

  // Stall while either source of the held instruction has a pending producer.
  // pending_q only changes at the edge, so a writeback that clears a bit
  // releases out_valid one cycle later, when op already holds wb_data.
  assign src1_pending = pending_q[b_rs1_q];
  assign src2_pending = pending_q[b_rs2_q];
  assign out_valid    = b_valid_q && !src1_pending && !src2_pending;
  assign handshake    = out_valid && out_ready;
  assign in_ready     = rst_n && (!b_valid_q || handshake);
  assign accept       = in_valid && in_ready;

  // Writeback matches against the incoming and the held sources (x0 never matches)
  assign wb_hit1_in = wb_wen && (wb_sel == in_rs1) && (in_rs1 != 5'd0);
  assign wb_hit2_in = wb_wen && (wb_sel == in_rs2) && (in_rs2 != 5'd0);
  assign wb_hit1_b  = wb_wen && (wb_sel == b_rs1_q) && (b_rs1_q != 5'd0);
  assign wb_hit2_b  = wb_wen && (wb_sel == b_rs2_q) && (b_rs2_q != 5'd0);

  // Scoreboard events
  assign wb_clears = wb_wen && (wb_sel != 5'd0);
  assign hs_sets   = handshake && b_rd_wen_q && (b_rd_q != 5'd0);

  // Operand resolution: x0 reads as zero; first cycle uses the RF read data
  assign opnd1 = (b_rs1_q == 5'd0) ? '0 : (use_rf1_q ? rf_rdata1 : op1_q);
  assign opnd2 = (b_rs2_q == 5'd0) ? '0 : (use_rf2_q ? rf_rdata2 : op2_q);

  assign out_rs1_val = opnd1;
  assign out_rs2_val = opnd2;
  assign out_rd      = b_rd_q;
  assign out_rd_wen  = b_rd_wen_q;
  assign out_pc      = b_pc_q;

  // Next state of stage B: load on accept, otherwise drain and refresh operands
  always_comb begin
    b_valid_d  = b_valid_q;
    b_rs1_d    = b_rs1_q;
    b_rs2_d    = b_rs2_q;
    b_rd_d     = b_rd_q;
    b_rd_wen_d = b_rd_wen_q;
    b_pc_d     = b_pc_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    use_rf1_d  = use_rf1_q;
    use_rf2_d  = use_rf2_q;

    if (accept) begin
      b_valid_d  = 1'b1;
      b_rs1_d    = in_rs1;
      b_rs2_d    = in_rs2;
      b_rd_d     = in_rd;
      b_rd_wen_d = in_rd_wen;
      b_pc_d     = in_pc;
      // The RF returns the pre-write value for a same-edge write, so bypass it
      op1_d      = wb_hit1_in ? wb_data : '0;
      use_rf1_d  = !wb_hit1_in;
      op2_d      = wb_hit2_in ? wb_data : '0;
      use_rf2_d  = !wb_hit2_in;
    end else begin
      if (handshake) begin
        b_valid_d = 1'b0;
      end
      if (b_valid_q) begin
        // A writeback to a held source wins over latching the RF read data
        if (wb_hit1_b) begin
          op1_d     = wb_data;
          use_rf1_d = 1'b0;
        end else if (use_rf1_q) begin
          op1_d     = rf_rdata1;
          use_rf1_d = 1'b0;
        end
        if (wb_hit2_b) begin
          op2_d     = wb_data;
          use_rf2_d = 1'b0;
        end else if (use_rf2_q) begin
          op2_d     = rf_rdata2;
          use_rf2_d = 1'b0;
        end
      end
    end
  end

  // Next state of the scoreboard: clear on writeback, set on issue (set wins)
  always_comb begin
    pending_d = pending_q;
    if (wb_clears) begin
      pending_d[wb_sel] = 1'b0;
    end
    if (hs_sets) begin
      pending_d[b_rd_q] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      b_valid_q  <= 1'b0;
      b_rs1_q    <= 5'd0;
      b_rs2_q    <= 5'd0;
      b_rd_q     <= 5'd0;
      b_rd_wen_q <= 1'b0;
      b_pc_q     <= 32'd0;
      op1_q      <= '0;
      op2_q      <= '0;
      use_rf1_q  <= 1'b0;
      use_rf2_q  <= 1'b0;
      pending_q  <= 32'd0;
    end else begin
      b_valid_q  <= b_valid_d;
      b_rs1_q    <= b_rs1_d;
      b_rs2_q    <= b_rs2_d;
      b_rd_q     <= b_rd_d;
      b_rd_wen_q <= b_rd_wen_d;
      b_pc_q     <= b_pc_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      use_rf1_q  <= use_rf1_d;
      use_rf2_q  <= use_rf2_d;
      pending_q  <= pending_d;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed bench for operand_fetch with a register file
// model, an expected-output queue and a monitor that checks every handshake.
module tb_operand_fetch;

  localparam int XLEN = 32;
  localparam int PW   = 102; // {pc, rd_wen, rd, rs2_val, rs1_val}

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // ---------------------------------------------------------------------
  // DUT signals
  // ---------------------------------------------------------------------
  logic            in_valid, in_ready;
  logic [4:0]      in_rs1, in_rs2, in_rd;
  logic            in_rd_wen;
  logic [31:0]     in_pc;
  logic [4:0]      rf_rsel1, rf_rsel2;
  logic [XLEN-1:0] rf_rdata1, rf_rdata2;
  logic            wb_wen;
  logic [4:0]      wb_sel;
  logic [XLEN-1:0] wb_data;
  logic            out_valid, out_ready;
  logic [XLEN-1:0] out_rs1_val, out_rs2_val;
  logic [4:0]      out_rd;
  logic            out_rd_wen;
  logic [31:0]     out_pc;

  operand_fetch #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_rd      (in_rd),
    .in_rd_wen  (in_rd_wen),
    .in_pc      (in_pc),
    .rf_rsel1   (rf_rsel1),
    .rf_rsel2   (rf_rsel2),
    .rf_rdata1  (rf_rdata1),
    .rf_rdata2  (rf_rdata2),
    .wb_wen     (wb_wen),
    .wb_sel     (wb_sel),
    .wb_data    (wb_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_rs1_val(out_rs1_val),
    .out_rs2_val(out_rs2_val),
    .out_rd     (out_rd),
    .out_rd_wen (out_rd_wen),
    .out_pc     (out_pc)
  );

  // Register file model: synchronous read returns the pre-write value
  logic [XLEN-1:0] rf_mem [32];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
      rf_rdata1 <= '0;
      rf_rdata2 <= '0;
    end else begin
      rf_rdata1 <= rf_mem[rf_rsel1];
      rf_rdata2 <= rf_mem[rf_rsel2];
      if (wb_wen && wb_sel != 5'd0) rf_mem[wb_sel] <= wb_data;
    end
  end

  // ---------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------
  logic [PW-1:0] exp_q[$];
  int            hs_cycles[$];
  int            n_checks = 0;
  int            n_fail   = 0;

  function automatic logic [PW-1:0] pack(input logic [31:0] pc, input logic wen,
                                         input logic [4:0] rd, input logic [31:0] v2,
                                         input logic [31:0] v1);
    return {pc, wen, rd, v2, v1};
  endfunction

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Monitor: every output handshake pops one expected response
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      logic [PW-1:0] got, exp;
      hs_cycles.push_back(cycle);
      got = pack(out_pc, out_rd_wen, out_rd, out_rs2_val, out_rs1_val);
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL out_unexpected: got %h expected nothing (cycle %0d)", got, cycle);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          n_fail++;
          $display("FAIL out_payload: got %h expected %h (cycle %0d)", got, exp, cycle);
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Driver tasks (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic wb_write(input logic [4:0] sel, input logic [31:0] data);
    wb_wen  = 1'b1;
    wb_sel  = sel;
    wb_data = data;
    step();
    wb_wen  = 1'b0;
  endtask

  // Present one instruction until accepted; optionally queue its response
  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic wen, input logic [31:0] pc,
                       input logic [31:0] e1, input logic [31:0] e2, input bit expect_out);
    bit acc;
    int tries;
    in_valid  = 1'b1;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_rd     = rd;
    in_rd_wen = wen;
    in_pc     = pc;
    if (expect_out) exp_q.push_back(pack(pc, wen, rd, e2, e1));
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 20) begin
      @(negedge clk);
      acc = in_ready;
      step();
      tries++;
    end
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_accept: pc %h not accepted within %0d cycles", pc, tries);
    end
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------
  logic [4:0]  sel_tbl [4];
  logic [31:0] val_tbl [4];

  initial begin
    int n0;
    sel_tbl = '{5'd5, 5'd6, 5'd7, 5'd0};
    val_tbl = '{32'h0000_1234, 32'hDEAD_BEEF, 32'h0000_AAAA, 32'h0};

    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_rs1    = 5'd1;
    in_rs2    = 5'd2;
    in_rd     = 5'd3;
    in_rd_wen = 1'b1;
    in_pc     = 32'hFFFF_0000;
    wb_wen    = 1'b0;
    wb_sel    = 5'd0;
    wb_data   = '0;
    out_ready = 1'b1;

    // Reset held 3 cycles with in_valid high
    repeat (3) begin
      @(negedge clk);
      chk("rst_in_ready", PW'(in_ready), PW'(1'b0));
      chk("rst_out_valid", PW'(out_valid), PW'(1'b0));
      chk("rst_out_zero", pack(out_pc, out_rd_wen, out_rd, out_rs2_val, out_rs1_val), '0);
    end
    step();
    rst_n = 1'b1;
    idle();
    @(negedge clk);
    chk("post_rst_in_ready", PW'(in_ready), PW'(1'b1));
    step();

    // Preload register file through the writeback port
    wb_write(5'd5, 32'h0000_1234);
    wb_write(5'd6, 32'hDEAD_BEEF);
    wb_write(5'd7, 32'h0000_0001);
    step();

    // Plain reads, including an x0 source
    issue(5'd5, 5'd6, 5'd10, 1'b0, 32'h100, 32'h0000_1234, 32'hDEAD_BEEF, 1'b1);
    issue(5'd6, 5'd0, 5'd0,  1'b0, 32'h104, 32'hDEAD_BEEF, 32'h0, 1'b1);
    idle();
    step();
    step();

    // Same-edge bypass: x7 is written while the reader is accepted
    wb_wen  = 1'b1;
    wb_sel  = 5'd7;
    wb_data = 32'h0000_AAAA;
    issue(5'd7, 5'd5, 5'd11, 1'b0, 32'h108, 32'h0000_AAAA, 32'h0000_1234, 1'b1);
    wb_wen = 1'b0;
    idle();
    step();
    step();

    // Scoreboard RAW: producer of x3, then a consumer that must wait
    issue(5'd1, 5'd2, 5'd3, 1'b1, 32'h10C, 32'h0, 32'h0, 1'b1);
    issue(5'd3, 5'd5, 5'd0, 1'b0, 32'h110, 32'h0000_0055, 32'h0000_1234, 1'b1);
    idle();
    repeat (3) begin
      @(negedge clk);
      chk("raw_stall", PW'(out_valid), PW'(1'b0));
      step();
    end
    wb_wen  = 1'b1;
    wb_sel  = 5'd3;
    wb_data = 32'h0000_0055;
    @(negedge clk);
    chk("raw_same_cycle_hold", PW'(out_valid), PW'(1'b0));
    step();
    wb_wen = 1'b0;
    @(negedge clk);
    chk("raw_release", PW'(out_valid), PW'(1'b1));
    step();
    @(negedge clk);
    chk("raw_pending3_clear", PW'(dut.pending_q[3]), PW'(1'b0));
    step();

    // Backpressure: payload must hold while execute is not ready
    out_ready = 1'b0;
    issue(5'd5, 5'd7, 5'd9, 1'b1, 32'h200, 32'h0000_1234, 32'h0000_AAAA, 1'b1);
    idle();
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", PW'(in_ready), PW'(1'b0));
      chk("bp_payload", pack(out_pc, out_rd_wen, out_rd, out_rs2_val, out_rs1_val),
          pack(32'h200, 1'b1, 5'd9, 32'h0000_AAAA, 32'h0000_1234));
      step();
    end
    out_ready = 1'b1;
    step();
    step();

    // Streaming: 8 back-to-back instructions with no hazards
    n0 = hs_cycles.size();
    for (int i = 0; i < 8; i++) begin
      issue(sel_tbl[i % 4], sel_tbl[(i + 1) % 4], 5'(16 + i), 1'b0, 32'h300 + 32'(4 * i),
            val_tbl[i % 4], val_tbl[(i + 1) % 4], 1'b1);
    end
    idle();
    for (int t = 0; t < 10 && hs_cycles.size() < n0 + 8; t++) begin
      @(negedge clk);
      #1;
    end
    if (hs_cycles.size() < n0 + 8) begin
      chk("stream_count", PW'(hs_cycles.size() - n0), PW'(8));
    end else begin
      chk("stream_consecutive", PW'(hs_cycles[n0 + 7] - hs_cycles[n0]), PW'(7));
    end
    step();
    step();

    // Set/clear collision on x4: handshake of rd=4 together with wb x4
    issue(5'd0, 5'd0, 5'd4, 1'b1, 32'h400, 32'h0, 32'h0, 1'b1);
    idle();
    wb_wen  = 1'b1;
    wb_sel  = 5'd4;
    wb_data = 32'h0000_0077;
    step();
    wb_wen = 1'b0;
    @(negedge clk);
    chk("collision_pending4", PW'(dut.pending_q[4]), PW'(1'b1));
    step();

    // Consumer of x4 stalls; reset discards it without a handshake
    issue(5'd4, 5'd0, 5'd0, 1'b0, 32'h404, 32'h0, 32'h0, 1'b0);
    idle();
    repeat (2) begin
      @(negedge clk);
      chk("x4_stall", PW'(out_valid), PW'(1'b0));
      step();
    end
    rst_n = 1'b0;
    step();
    @(negedge clk);
    chk("midrst_out_valid", PW'(out_valid), PW'(1'b0));
    chk("midrst_pending", PW'(dut.pending_q), PW'(32'h0));
    chk("midrst_in_ready", PW'(in_ready), PW'(1'b0));
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_release_ready", PW'(in_ready), PW'(1'b1));
    chk("midrst_out_valid_after", PW'(out_valid), PW'(1'b0));
    step();
    step();

    chk("exp_q_drained", PW'(exp_q.size()), PW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Operand-fetch stage that sits between decode and execute and is the read-side client of the core's 32x32 register file. It accepts one decoded instruction per cycle and drives the register file's synchronous read selects. It collects the read data one cycle later and bypasses same-cycle and in-stage writebacks. A 32-bit scoreboard holds any instruction whose source register still has an in-flight producer downstream.

## Interface
- XLEN, 32, data width of register values
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous reset, active-low
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts instruction this cycle
- in_rs1, in_rs2  in  5  source register indices
- in_rd  in  5  destination index
- in_rd_wen  in  1  instruction writes in_rd
- in_pc  in  32  instruction PC, passed through
- rf_rsel1, rf_rsel2  out  5  register file read selects; data returned on the next cycle
- rf_rdata1, rf_rdata2  in  XLEN  register file read data
- wb_wen, wb_sel, wb_data  in  1/5/XLEN  the writeback being applied to the register file this cycle
- out_valid  out  1  operands valid toward execute
- out_ready  in  1  execute accepts
- out_rs1_val, out_rs2_val  out  XLEN  resolved operands
- out_rd, out_rd_wen, out_pc  out  5/1/32  passed through

## Operation
- **Single holding stage (B).**
  - Stage B contents: valid, rs1, rs2, rd, rd_wen, pc, op1, op2, and use_rf1/use_rf2 flags.
  - in_ready = rst_n && (!B.valid || (out_valid && out_ready)).
- **Read selects.** rf_rsel1/2 = in_rs1/in_rs2, combinational at all times.
- **Accept edge** (in_valid && in_ready):
  - Load B.
  - For each source: if wb_wen && wb_sel == rs && rs != 0, set op = wb_data and use_rf = 0 (the register file returns the pre-write value). Otherwise set use_rf = 1.
- **First cycle in B.**
  - Operand = use_rf ? rf_rdata : op.
  - At the end of this cycle, latch the operand into op and clear use_rf, whether or not the output handshake fires.
- **While held in B.** Each edge with wb_wen && wb_sel == rs && rs != 0 overwrites op with wb_data. This has priority over the rf_rdata latch.
- **x0.** A source index of 0 always yields 0.
- **Scoreboard** (pending[31:0]):
  - On an output handshake with out_rd_wen && out_rd != 0, set pending[out_rd].
  - On wb_wen && wb_sel != 0, clear pending[wb_sel].
  - If set and clear hit the same index in the same cycle, set wins.
  - pending[0] is constant 0.
- **out_valid** = B.valid && !pending[B.rs1] && !pending[B.rs2].
  - A writeback that clears a pending bit does not release out_valid in that same cycle. Release is on the next cycle, with op already holding wb_data.
- **Output register.** B clears on a handshake unless a new instruction is accepted on the same edge.
- **Reset** (rst_n low at an edge):
  - B.valid = 0, pending = 0, op1/op2 = 0, use_rf = 0.
  - out_valid = 0, out_* = 0.
  - in_ready = 0 while rst_n is low.
  - Any instruction in flight is discarded without a handshake.

## Timing
- Latency: accepted at edge N, out_valid earliest in cycle N+1.
- Throughput: 1 instruction/cycle with out_ready held high and no hazards.
- RAW on an in-flight producer: out_valid rises in the cycle after the matching writeback.
- Payload stability: while out_valid && !out_ready, the out_* signals are stable except operand updates.
  - Operand updates occur only on non-pending registers, and are legal only when the write carries the same architectural value.
- No combinational path from rf_rdata to in_ready. in_ready depends on out_ready combinationally.

## Test plan
- **Reset.** Hold rst_n=0 for 3 cycles with in_valid=1, then release.
  - During reset: in_ready=0, out_valid=0, all out_* = 0.
  - Cycle after release: in_ready=1.
- **Plain read.**
  - Preload x5=0x00001234 and x6=0xDEADBEEF.
  - Issue rs1=5, rs2=6 → next cycle out_valid=1, out_rs1_val=0x00001234, out_rs2_val=0xDEADBEEF.
  - Issue rs2=0 → out_rs2_val=0.
- **Same-edge bypass.**
  - x7 holds 0x1. In the accept cycle drive wb x7=0x0000AAAA.
  - Required: out_rs1_val=0x0000AAAA, not 0x1.
- **Scoreboard RAW.**
  - Issue producer rd=3 and handshake it. Issue consumer rs1=3: out_valid stays 0.
  - Wb x3=0x55 in cycle K → out_valid=1 in K+1 with out_rs1_val=0x55.
  - pending[3] clear afterwards.
- **Backpressure and streaming.**
  - out_ready=0 for 5 cycles with an instruction in B → in_ready=0 and out_* stable.
  - Then hold in_valid=out_ready=1 for 8 instructions → 8 handshakes in 8 consecutive cycles, with in-order PCs.
- **Set/clear collision and reset mid-flight.**
  - Handshake with rd=4 in the same cycle as wb x4 → pending[4]=1 afterwards.
  - Assert rst_n=0 with B valid and pending[4]=1 → out_valid=0 and pending=0 the following cycle.
